// File: rtl/servo_pwm_capture.sv
// Servo/RC PWM capture: measures high time (duty ticks) and rise-to-rise period,
// with lock, signal-loss and over-range status.
module servo_pwm_capture #(
   parameter int unsigned CLK_HZ          = 125000000,
   parameter int unsigned PWM_FREQ        = 50,
   parameter int unsigned DUTY_MAX        = 1000,
   parameter int unsigned TIMEOUT_PERIODS = 3
) (
   input  logic        clk,
   input  logic        rstp,
   input  logic        pwm_in,
   output logic [9:0]  duty,
   output logic        duty_valid,
   output logic [11:0] period,
   output logic        period_valid,
   output logic        locked,
   output logic        sig_lost,
   output logic        overrange
);

   localparam int unsigned TICK_DIV      = CLK_HZ / (PWM_FREQ * 1000);
   localparam int unsigned PRE_W         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned TIMEOUT_TICKS = TIMEOUT_PERIODS * 1000;

   typedef enum logic [1:0] {SYNC, HIGH, LOW} state_t;

   state_t state, state_next;

   logic s1, s2, s3;
   logic rise, fall;
   logic v1, v2;
   logic armed;

   logic [PRE_W-1:0] pre;
   logic             wrap;
   logic             tick;
   logic             timeout;

   logic [9:0]  high_cnt;
   logic [11:0] per_cnt;
   logic [11:0] idle_cnt;

   logic start, cap_duty, cap_per, lose, cnt_high, cnt_per;

   // v1/v2 track synchronizer fill so reset values are never mistaken for a low input
   always_ff @(posedge clk or posedge rstp) begin
      if (rstp) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         s3   <= 1'b0;
         rise <= 1'b0;
         fall <= 1'b0;
         v1   <= 1'b0;
         v2   <= 1'b0;
      end else begin
         s1   <= pwm_in;
         s2   <= s1;
         s3   <= s2;
         rise <= s2 & ~s3;
         fall <= ~s2 & s3;
         v1   <= 1'b1;
         v2   <= v1;
      end
   end

   assign wrap    = (pre == PRE_W'(TICK_DIV - 1));
   assign tick    = wrap & ~rise & ~fall;
   assign timeout = (state != SYNC) && (32'(idle_cnt) >= TIMEOUT_TICKS) && !rise && !fall;

   // The rise cycle itself is prescaler phase 0, so it reloads to phase 1
   always_ff @(posedge clk or posedge rstp) begin
      if (rstp)
         pre <= '0;
      else if (rise)
         pre <= PRE_W'((TICK_DIV > 1) ? 1 : 0);
      else if (wrap)
         pre <= '0;
      else
         pre <= pre + 1'b1;
   end

   always_ff @(posedge clk or posedge rstp) begin
      if (rstp)
         state <= SYNC;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      start      = 1'b0;
      cap_duty   = 1'b0;
      cap_per    = 1'b0;
      lose       = 1'b0;
      cnt_high   = 1'b0;
      cnt_per    = 1'b0;
      case (state)
         SYNC: begin
            if (rise && armed) begin
               start      = 1'b1;
               state_next = HIGH;
            end
         end
         HIGH: begin
            if (fall) begin
               if (high_cnt == '0) begin
                  state_next = SYNC;
               end else begin
                  cap_duty   = 1'b1;
                  state_next = LOW;
               end
            end else if (timeout) begin
               lose       = 1'b1;
               state_next = SYNC;
            end else if (tick) begin
               cnt_high = 1'b1;
               cnt_per  = 1'b1;
            end
         end
         LOW: begin
            if (rise) begin
               cap_per    = 1'b1;
               start      = 1'b1;
               state_next = HIGH;
            end else if (timeout) begin
               lose       = 1'b1;
               state_next = SYNC;
            end else if (tick) begin
               cnt_per = 1'b1;
            end
         end
         default: state_next = SYNC;
      endcase
   end

   always_ff @(posedge clk or posedge rstp) begin
      if (rstp) begin
         high_cnt <= '0;
         per_cnt  <= '0;
         idle_cnt <= '0;
         armed    <= 1'b0;
      end else begin
         if (start)
            high_cnt <= '0;
         else if (cnt_high && high_cnt != '1)
            high_cnt <= high_cnt + 1'b1;

         if (start)
            per_cnt <= '0;
         else if (cnt_per && per_cnt != '1)
            per_cnt <= per_cnt + 1'b1;

         if (rise || fall)
            idle_cnt <= '0;
         else if (tick && idle_cnt != '1)
            idle_cnt <= idle_cnt + 1'b1;

         // armed only by a genuinely low synced input while (re)entering or sitting in SYNC
         armed <= (state_next == SYNC) && (armed || (v2 && !s2));
      end
   end

   always_ff @(posedge clk or posedge rstp) begin
      if (rstp) begin
         duty         <= '0;
         duty_valid   <= 1'b0;
         period       <= '0;
         period_valid <= 1'b0;
         locked       <= 1'b0;
         sig_lost     <= 1'b0;
         overrange    <= 1'b0;
      end else begin
         duty_valid   <= cap_duty;
         period_valid <= cap_per;
         if (cap_duty) begin
            if (32'(high_cnt) > DUTY_MAX) begin
               duty      <= 10'(DUTY_MAX);
               overrange <= 1'b1;
            end else begin
               duty      <= high_cnt;
               overrange <= 1'b0;
            end
         end
         if (cap_per) begin
            period   <= per_cnt;
            locked   <= (per_cnt >= 12'd900) && (per_cnt <= 12'd1100);
            sig_lost <= 1'b0;
         end else if (lose) begin
            sig_lost <= 1'b1;
            locked   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_servo_pwm_capture.sv
// Bench for servo_pwm_capture: frames described in ticks, expected strobes
// derived from frame lengths and queued for an always-on strobe monitor.
module tb_servo_pwm_capture;

   localparam int D = 2;  // clocks per tick at CLK_HZ=100000, PWM_FREQ=50

   logic        clk = 1'b0;
   logic        rstp;
   logic        pwm_in;
   logic [9:0]  duty;
   logic        duty_valid;
   logic [11:0] period;
   logic        period_valid;
   logic        locked;
   logic        sig_lost;
   logic        overrange;

   always #5 clk = ~clk;

   servo_pwm_capture #(
      .CLK_HZ(100000),
      .PWM_FREQ(50),
      .DUTY_MAX(1000),
      .TIMEOUT_PERIODS(3)
   ) dut (
      .clk(clk),
      .rstp(rstp),
      .pwm_in(pwm_in),
      .duty(duty),
      .duty_valid(duty_valid),
      .period(period),
      .period_valid(period_valid),
      .locked(locked),
      .sig_lost(sig_lost),
      .overrange(overrange)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // reference model: one frame = h ticks high, p ticks rise-to-rise
   int exp_duty[$];
   bit exp_ov[$];
   int exp_per[$];
   bit exp_lock[$];
   bit in_frame = 1'b0;
   int last_p = 0;
   int last_duty = 0;

   function automatic void model_rise();
      if (in_frame) begin
         exp_per.push_back(last_p > 4095 ? 4095 : last_p);
         exp_lock.push_back(last_p >= 900 && last_p <= 1100);
      end
   endfunction

   task automatic send_frame(input int h, input int p);
      int hc;
      model_rise();
      hc = (h > 1023) ? 1023 : h;
      last_duty = (hc > 1000) ? 1000 : hc;
      exp_duty.push_back(last_duty);
      exp_ov.push_back(hc > 1000);
      in_frame = 1'b1;
      last_p = p;
      pwm_in = 1'b1;
      repeat (h * D) @(negedge clk);
      pwm_in = 1'b0;
      repeat ((p - h) * D) @(negedge clk);
   endtask

   task automatic send_glitch(input int low_clks);
      model_rise();
      in_frame = 1'b0;
      pwm_in = 1'b1;
      @(negedge clk);
      pwm_in = 1'b0;
      repeat (low_clks) @(negedge clk);
   endtask

   bit last_dv = 1'b0;
   bit last_pv = 1'b0;

   always @(negedge clk) begin
      if (duty_valid) begin
         check("dv_width", 32'(last_dv), 0);
         check("dv_pending", 32'(exp_duty.size() > 0), 1);
         if (exp_duty.size() > 0) begin
            check("duty", 32'(duty), exp_duty.pop_front());
            check("overrange", 32'(overrange), 32'(exp_ov.pop_front()));
         end
      end
      if (period_valid) begin
         check("pv_width", 32'(last_pv), 0);
         check("pv_pending", 32'(exp_per.size() > 0), 1);
         if (exp_per.size() > 0) begin
            check("period", 32'(period), exp_per.pop_front());
            check("locked", 32'(locked), 32'(exp_lock.pop_front()));
            check("sig_lost_clr", 32'(sig_lost), 0);
         end
      end
      last_dv = duty_valid;
      last_pv = period_valid;
   end

   int h, p;

   initial begin
      rstp   = 1'b1;
      pwm_in = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_duty", 32'(duty), 0);
      check("rst_dv", 32'(duty_valid), 0);
      check("rst_period", 32'(period), 0);
      check("rst_pv", 32'(period_valid), 0);
      check("rst_locked", 32'(locked), 0);
      check("rst_lost", 32'(sig_lost), 0);
      check("rst_ovr", 32'(overrange), 0);
      rstp = 1'b0;
      repeat (20) @(negedge clk);

      // nominal frames, then high-time changes on consecutive frames
      send_frame(77, 1000);
      send_frame(77, 1000);
      check("nom_duty", 32'(duty), 77);
      check("nom_period", 32'(period), 1000);
      check("nom_locked", 32'(locked), 1);
      send_frame(28, 1000);
      send_frame(125, 1000);
      send_frame(77, 1000);
      check("chg_locked", 32'(locked), 1);

      repeat (5) begin
         h = $urandom_range(1, 1100);
         p = h + $urandom_range(20, 400);
         send_frame(h, p);
      end
      send_frame(77, 1000);

      // reset mid-pulse, released while input still high
      model_rise();
      in_frame = 1'b0;
      pwm_in = 1'b1;
      repeat (50) @(negedge clk);
      rstp = 1'b1;
      @(negedge clk);
      check("mid_rst_duty", 32'(duty), 0);
      check("mid_rst_period", 32'(period), 0);
      check("mid_rst_locked", 32'(locked), 0);
      repeat (2) @(negedge clk);
      rstp = 1'b0;
      repeat (100) @(negedge clk);
      pwm_in = 1'b0;
      repeat (100) @(negedge clk);
      check("ign_duty", 32'(duty), 0);
      check("ign_period", 32'(period), 0);
      check("ign_lost", 32'(sig_lost), 0);
      send_frame(77, 1000);
      send_frame(77, 1000);

      // stuck-high input
      model_rise();
      in_frame = 1'b0;
      pwm_in = 1'b1;
      repeat (2900 * D) @(negedge clk);
      check("pre_timeout", 32'(sig_lost), 0);
      repeat (110 * D) @(negedge clk);
      check("timeout_lost", 32'(sig_lost), 1);
      check("timeout_locked", 32'(locked), 0);
      check("timeout_duty", 32'(duty), 32'(last_duty));
      pwm_in = 1'b0;
      repeat (40) @(negedge clk);
      send_frame(77, 1000);
      check("lost_held", 32'(sig_lost), 1);
      send_frame(77, 1000);
      check("lost_cleared", 32'(sig_lost), 0);

      // 1-clk glitch then recovery
      send_glitch(40);
      check("glitch_duty", 32'(duty), 77);
      send_frame(125, 1000);
      send_frame(77, 1000);

      // over-range high time
      send_frame(1200, 1500);
      check("ovr_flag", 32'(overrange), 1);
      check("ovr_duty", 32'(duty), 1000);
      send_frame(77, 1000);
      check("ovr_period", 32'(period), 1500);
      check("ovr_clear", 32'(overrange), 0);
      send_frame(77, 1000);

      repeat (10) @(negedge clk);
      check("duty_left", 32'(exp_duty.size()), 0);
      check("period_left", 32'(exp_per.size()), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/servo_pwm_capture.md
Name: servo_pwm_capture

Overview:
- Receive-side counterpart of the servo PWM generator: measures an incoming servo or RC PWM signal.
- Reports the high time in the same duty units the generator uses, 1/1000 of the nominal period (20 us at 50 Hz). A captured duty can be fed straight back into the generator or shown on the FND display.
- Also reports the measured period, lock status, signal-loss and over-range flags.
- Sits between an external pin (or the local generator's output, for loopback test) and the display/control logic.

Parameters:
- CLK_HZ, 125000000, system clock frequency in Hz.
- PWM_FREQ, 50, nominal PWM frame rate in Hz.
- DUTY_MAX, 1000, largest reportable duty (one full period in ticks).
- TIMEOUT_PERIODS, 3, number of nominal periods without any edge before signal loss is declared.
- Derived: TICK_DIV = CLK_HZ/(PWM_FREQ*1000) clocks per tick (2500 at defaults). TICK_DIV must be >= 1.

Ports:
- clk, input, 1, system clock.
- rstp, input, 1, asynchronous active-high reset.
- pwm_in, input, 1, asynchronous PWM input.
- duty, output, 10, last captured high time in ticks; held between captures.
- duty_valid, output, 1, one-clk strobe when duty updates.
- period, output, 12, last measured rise-to-rise time in ticks; saturates at 4095.
- period_valid, output, 1, one-clk strobe when period updates.
- locked, output, 1, last period was within [900,1100] ticks.
- sig_lost, output, 1, no edge seen within the timeout.
- overrange, output, 1, last high time exceeded DUTY_MAX.

Behaviour:
- Clocking and reset: clk is the clock. rstp is an asynchronous, active-high reset.
- Reset state: all outputs 0, all counters 0, FSM in SYNC.
- Input path:
  - pwm_in passes through a 2-FF synchronizer, then a registered edge detector (rise/fall pulses).
  - Edge-to-internal-event latency is 3 clk.
- Tick prescaler:
  - Cleared on every rise event.
  - Otherwise counts 0..TICK_DIV-1 and emits a tick on the wrap.
  - Only whole ticks are counted; a partial tick is truncated.
- Counters (all counters saturate, none wrap):
  - high_cnt: 10 bit, saturates at 1023.
  - per_cnt: 12 bit, saturates at 4095.
  - idle_cnt: ticks since the last edge, 12 bit.
- FSM states:
  - SYNC: wait for the synced input to be low, then a rise. Any pulse already in progress after reset or loss is discarded. On rise: clear high_cnt and per_cnt, go to HIGH.
  - HIGH: on each tick, increment high_cnt and per_cnt. On fall:
    - high_cnt == 0: treat as a glitch; go to SYNC with no strobe.
    - 1 <= high_cnt <= DUTY_MAX: duty <= high_cnt, overrange <= 0, duty_valid pulses, go to LOW.
    - high_cnt > DUTY_MAX: duty <= DUTY_MAX, overrange <= 1, duty_valid pulses, go to LOW.
  - LOW: on each tick, increment per_cnt. On rise:
    - period <= per_cnt and period_valid pulses.
    - locked <= (900 <= per_cnt <= 1100).
    - Clear counters, go to HIGH. The next pulse is measured back-to-back with no lost frame.
- Strobe timing: duty_valid and period_valid each assert for exactly 1 clk, in the cycle after the edge event. duty/period are registered in that same cycle.
- Timeout:
  - idle_cnt clears on any edge event and increments on ticks.
  - At TIMEOUT_PERIODS*1000 ticks (any state except SYNC): sig_lost <= 1, locked <= 0, FSM -> SYNC.
  - duty and period hold their last values; no strobe.
  - This covers both a stuck-high and a stuck-low input.
- sig_lost clears on the next period_valid.
- Simultaneous events: a tick and an edge in the same cycle — the edge action wins and the tick is not counted. A timeout and an edge in the same cycle — the edge wins and no timeout is declared.
- Reset mid-measurement: asynchronous clear to the reset state; the partial frame is discarded.

Test Plan:
- Run with CLK_HZ=100000 (TICK_DIV=2, 2 clk per tick).
- Reset, then 20 ms frames with 1.54 ms high (77 ticks high, 1000 ticks period) -> after the 1st full frame: duty=77 with duty_valid, period=1000 with period_valid, locked=1. Each strobe is exactly 1 clk wide.
- Change high time to 0.56 ms, then 2.5 ms -> duty=28, then duty=125 on consecutive frames. No frame is missed and locked stays 1.
- Assert rstp mid-pulse, release while pwm_in is high -> that pulse is ignored (SYNC). First duty_valid comes on the next complete pulse; all outputs are 0 until then.
- Hold pwm_in high after a rise -> at 3000 ticks: sig_lost=1, locked=0, duty holds its previous value, no duty_valid. Resume normal frames -> sig_lost clears at the first period_valid.
- Send a 1-clk glitch pulse (high_cnt=0) -> no strobe, FSM returns to SYNC. Next normal frame is captured correctly.
- Send a 1200-tick high / 1500-tick period frame -> duty=1000, overrange=1, period=1500, locked=0. A following in-range frame -> overrange=0.
